mm_access_ctrl: RTL and testbench
=================================

MM_ACCESS_CTRL -- requirements
Module: mm_access_ctrl

Interface
REQ-001 Clocking SHALL be one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter ADDR_W, default 14, SHALL set the MM address width.
REQ-003 Parameter DATA_W, default 64, SHALL set the MM data width.
REQ-004 Parameter TIMEOUT, default 256, SHALL set the read-wait limit in clk cycles (legal range 2..65535).
REQ-005 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  sync reset, active high
  iREQ_VALID  in  1  host request valid
  oREQ_READY  out  1  block can accept a request
  iREQ_WR  in  1  1 = write, 0 = read
  iREQ_ADDR  in  ADDR_W  request address
  iREQ_WDATA  in  DATA_W  write data
  oRSP_VALID  out  1  response valid
  iRSP_READY  in  1  host accepts response
  oRSP_DATA  out  DATA_W  read data, or 0 for a write
  oRSP_ERR  out  1  read timed out
  oMM_WR_EN  out  1  write pulse to the address decoder
  oMM_RD_EN  out  1  read pulse to the address decoder
  oMM_ADDR  out  ADDR_W  address to the decoder
  oMM_WR_DATA  out  DATA_W  write data to the decoder
  iMM_RD_DATA  in  DATA_W  decoder read data
  iMM_RD_DATA_V  in  1  decoder read data valid, 1-cycle pulse
  oRD_CNT, oWR_CNT, oTO_CNT  out  32 each  read, write and timeout counters

Function
REQ-006 The FSM SHALL have four states, IDLE, ISSUE, WAIT_RD and RESP, with one request outstanding at most.
REQ-007 oREQ_READY SHALL be 1 only in IDLE; iREQ_VALID&&oREQ_READY in cycle T SHALL capture iREQ_WR, iREQ_ADDR and iREQ_WDATA and go to ISSUE.
REQ-008 In ISSUE (cycle T+1), exactly one of oMM_WR_EN or oMM_RD_EN SHALL be high for one cycle, with oMM_ADDR and oMM_WR_DATA registered from the captured values.
REQ-009 oMM_ADDR and oMM_WR_DATA SHALL hold their last values outside ISSUE.
REQ-010 A write SHALL go ISSUE->RESP with oRSP_DATA=0 and oRSP_ERR=0, so oRSP_VALID is first high at T+2.
REQ-011 A read SHALL go ISSUE->WAIT_RD with the wait timer cleared to 0; the timer SHALL increment once per WAIT_RD cycle.
REQ-012 In WAIT_RD, iMM_RD_DATA_V=1 SHALL capture iMM_RD_DATA into oRSP_DATA, set oRSP_ERR=0 and go to RESP.
REQ-013 In WAIT_RD, timer==TIMEOUT-1 with iMM_RD_DATA_V=0 SHALL set oRSP_DATA={32'hDEAD_BEEF, zero pad, captured addr}, set oRSP_ERR=1 and go to RESP.
REQ-014 If iMM_RD_DATA_V=1 in the timeout cycle, the data SHALL win and no timeout SHALL be recorded.
REQ-015 In RESP, oRSP_VALID SHALL be 1 and oRSP_DATA/oRSP_ERR SHALL be stable until iRSP_READY=1, then the FSM SHALL go to IDLE; the response SHALL be held indefinitely with no timeout.
REQ-016 iMM_RD_DATA_V SHALL be ignored in IDLE, ISSUE and RESP; late data after a timeout SHALL be discarded.
REQ-017 Back-to-back requests SHALL be possible: RESP->IDLE in cycle N allows a new accept in cycle N+1.

Reset
REQ-018 While rst=1: state IDLE, oREQ_READY=0, oRSP_VALID=0, oRSP_DATA=0, oRSP_ERR=0, oMM_WR_EN=0, oMM_RD_EN=0, oMM_ADDR=0, oMM_WR_DATA=0, timer=0, all counters=0.
REQ-019 Reset asserted mid-transaction SHALL abort it with no response; the first cycle after rst deasserts SHALL show oREQ_READY=1.

Configuration
REQ-020 With macro MM_ACCESS_STATS_EN defined: oRD_CNT SHALL +1 per read issue, oWR_CNT +1 per write issue and oTO_CNT +1 per timeout, each saturating at 32'hFFFF_FFFF.
REQ-021 Without MM_ACCESS_STATS_EN: oRD_CNT, oWR_CNT and oTO_CNT SHALL be constant 0 with no counter flops; all other behaviour is identical.

Verification
REQ-022 Write addr 14'h0010, data 64'h1234 accepted at T -> oMM_WR_EN=1 at T+1 with that addr/data, oRSP_VALID=1 at T+2 with data 0, err 0.
REQ-023 Read addr 14'h0400, iMM_RD_DATA_V with 64'hCAFE three cycles after oMM_RD_EN -> oRSP_DATA=64'hCAFE, oRSP_ERR=0.
REQ-024 TIMEOUT=8, read addr 14'h3FFF, no valid -> RESP after 8 WAIT_RD cycles, data {32'hDEAD_BEEF,18'b0,14'h3FFF}, err=1, oTO_CNT=1 (macro on); a later valid pulse changes nothing.
REQ-025 iRSP_READY held 0 for 10 cycles -> oRSP_VALID, data and err stable, oREQ_READY=0, a pending iREQ_VALID is not accepted.
REQ-026 rst pulsed while in WAIT_RD -> all outputs zero, no response ever issued for that read, next request completes normally.
REQ-027 Valid and timeout in the same cycle (TIMEOUT=4, valid on the 4th WAIT_RD cycle) -> err=0, captured data returned, oTO_CNT unchanged.

Source files
------------

// File: rtl/mm_access_ctrl.sv
// -----------------------------------------------------------------------------
// mm_access_ctrl
//
// Purpose:
//   Bridges a simple valid/ready host request channel to a memory-mapped
//   register decoder. At most one request is in flight. A write is issued as
//   a one-cycle write pulse and acknowledged immediately. A read is issued as
//   a one-cycle read pulse, then the block waits for the decoder's data-valid
//   pulse or a timeout, whichever comes first. The response is held until the
//   host takes it.
//
// Optional feature:
//   Define MM_ACCESS_STATS_EN to enable the saturating read/write/timeout
//   counters. Without it the counter outputs are tied to zero and no counter
//   flops exist.
//
// Parameters:
//   ADDR_W   MM address width
//   DATA_W   MM data width (must be at least 32 + ADDR_W)
//   TIMEOUT  read-wait limit in clk cycles, 2..65535
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   iREQ_VALID / oREQ_READY        request handshake
//   iREQ_WR, iREQ_ADDR, iREQ_WDATA request kind, address, write data
//   oRSP_VALID / iRSP_READY        response handshake
//   oRSP_DATA, oRSP_ERR            read data (0 for writes), timeout flag
//   oMM_WR_EN, oMM_RD_EN           one-cycle access strobes to the decoder
//   oMM_ADDR, oMM_WR_DATA          address and write data to the decoder
//   iMM_RD_DATA, iMM_RD_DATA_V     decoder read data and its valid pulse
//   oRD_CNT, oWR_CNT, oTO_CNT      read, write and timeout counters
// -----------------------------------------------------------------------------
module mm_access_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iREQ_VALID,
    output logic              oREQ_READY,
    input  logic              iREQ_WR,
    input  logic [ADDR_W-1:0] iREQ_ADDR,
    input  logic [DATA_W-1:0] iREQ_WDATA,
    output logic              oRSP_VALID,
    input  logic              iRSP_READY,
    output logic [DATA_W-1:0] oRSP_DATA,
    output logic              oRSP_ERR,
    output logic              oMM_WR_EN,
    output logic              oMM_RD_EN,
    output logic [ADDR_W-1:0] oMM_ADDR,
    output logic [DATA_W-1:0] oMM_WR_DATA,
    input  logic [DATA_W-1:0] iMM_RD_DATA,
    input  logic              iMM_RD_DATA_V,
    output logic [31:0]       oRD_CNT,
    output logic [31:0]       oWR_CNT,
    output logic [31:0]       oTO_CNT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int         PAD_W      = DATA_W - 32 - ADDR_W;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [15:0]         timer_q, timer_d;
    logic [DATA_W-1:0]   rspData_q, rspData_d;
    logic                rspErr_q, rspErr_d;

    logic                accept;
    logic                rdTimeout;
    logic [DATA_W-1:0]   timeoutWord;

    assign accept = iREQ_VALID && oREQ_READY;

    // Data arriving in the last wait cycle wins, so a timeout needs no valid.
    assign rdTimeout = (state_q == WAIT_RD) && !iMM_RD_DATA_V &&
                       (timer_q == TIMER_LAST);

    // Timeout marker carries the offending address in the low bits.
    assign timeoutWord = {32'hDEAD_BEEF, {PAD_W{1'b0}}, addr_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = wr_q ? RESP : WAIT_RD;
            WAIT_RD: if (iMM_RD_DATA_V || (timer_q == TIMER_LAST)) state_d = RESP;
            RESP:    if (iRSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; strobes are gated by rst so nothing leaks while in reset
    always_comb begin
        oREQ_READY = (state_q == IDLE) && !rst;
        oRSP_VALID = (state_q == RESP) && !rst;
        oMM_WR_EN  = (state_q == ISSUE) && wr_q && !rst;
        oMM_RD_EN  = (state_q == ISSUE) && !wr_q && !rst;
    end

    // The captured request doubles as the decoder address/data registers, so
    // they are valid in ISSUE and simply hold their values afterwards.
    assign oMM_ADDR    = addr_q;
    assign oMM_WR_DATA = wdata_q;
    assign oRSP_DATA   = rspData_q;
    assign oRSP_ERR    = rspErr_q;

    // Datapath next-state: capture, wait timer and response payload
    always_comb begin
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        timer_d   = timer_q;
        rspData_d = rspData_q;
        rspErr_d  = rspErr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = iREQ_WR;
                    addr_d  = iREQ_ADDR;
                    wdata_d = iREQ_WDATA;
                end
            end
            ISSUE: begin
                timer_d = '0;
                if (wr_q) begin
                    rspData_d = '0;
                    rspErr_d  = 1'b0;
                end
            end
            WAIT_RD: begin
                timer_d = timer_q + 16'd1;
                if (iMM_RD_DATA_V) begin
                    rspData_d = iMM_RD_DATA;
                    rspErr_d  = 1'b0;
                end else if (rdTimeout) begin
                    rspData_d = timeoutWord;
                    rspErr_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            timer_q   <= '0;
            rspData_q <= '0;
            rspErr_q  <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            timer_q   <= timer_d;
            rspData_q <= rspData_d;
            rspErr_q  <= rspErr_d;
        end
    end

`ifdef MM_ACCESS_STATS_EN
    logic [31:0] rdCnt_q, rdCnt_d;
    logic [31:0] wrCnt_q, wrCnt_d;
    logic [31:0] toCnt_q, toCnt_d;

    // Saturating event counters: issues are counted in ISSUE, timeouts when
    // the wait ends without data.
    always_comb begin
        rdCnt_d = rdCnt_q;
        wrCnt_d = wrCnt_q;
        toCnt_d = toCnt_q;
        if ((state_q == ISSUE) && !wr_q && (rdCnt_q != 32'hFFFF_FFFF)) begin
            rdCnt_d = rdCnt_q + 32'd1;
        end
        if ((state_q == ISSUE) && wr_q && (wrCnt_q != 32'hFFFF_FFFF)) begin
            wrCnt_d = wrCnt_q + 32'd1;
        end
        if (rdTimeout && (toCnt_q != 32'hFFFF_FFFF)) begin
            toCnt_d = toCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdCnt_q <= '0;
            wrCnt_q <= '0;
            toCnt_q <= '0;
        end else begin
            rdCnt_q <= rdCnt_d;
            wrCnt_q <= wrCnt_d;
            toCnt_q <= toCnt_d;
        end
    end

    assign oRD_CNT = rdCnt_q;
    assign oWR_CNT = wrCnt_q;
    assign oTO_CNT = toCnt_q;
`else
    assign oRD_CNT = '0;
    assign oWR_CNT = '0;
    assign oTO_CNT = '0;
`endif

endmodule

// File: tb/tb_mm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mm_access_ctrl
//
// Purpose:
//   Directed bench for mm_access_ctrl built with TIMEOUT=8. Expected responses
//   are queued when a request is issued; an independent monitor pops and
//   compares them whenever a response handshake is presented. Decoder-side
//   strobes, hold behaviour, reset and counters are checked inline.
// -----------------------------------------------------------------------------
module tb_mm_access_ctrl;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 8;

`ifdef MM_ACCESS_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              iREQ_VALID;
    logic              oREQ_READY;
    logic              iREQ_WR;
    logic [ADDR_W-1:0] iREQ_ADDR;
    logic [DATA_W-1:0] iREQ_WDATA;
    logic              oRSP_VALID;
    logic              iRSP_READY;
    logic [DATA_W-1:0] oRSP_DATA;
    logic              oRSP_ERR;
    logic              oMM_WR_EN;
    logic              oMM_RD_EN;
    logic [ADDR_W-1:0] oMM_ADDR;
    logic [DATA_W-1:0] oMM_WR_DATA;
    logic [DATA_W-1:0] iMM_RD_DATA;
    logic              iMM_RD_DATA_V;
    logic [31:0]       oRD_CNT;
    logic [31:0]       oWR_CNT;
    logic [31:0]       oTO_CNT;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } rsp_t;

    rsp_t expQ[$];
    rsp_t monExp;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    mm_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .iREQ_VALID   (iREQ_VALID),
        .oREQ_READY   (oREQ_READY),
        .iREQ_WR      (iREQ_WR),
        .iREQ_ADDR    (iREQ_ADDR),
        .iREQ_WDATA   (iREQ_WDATA),
        .oRSP_VALID   (oRSP_VALID),
        .iRSP_READY   (iRSP_READY),
        .oRSP_DATA    (oRSP_DATA),
        .oRSP_ERR     (oRSP_ERR),
        .oMM_WR_EN    (oMM_WR_EN),
        .oMM_RD_EN    (oMM_RD_EN),
        .oMM_ADDR     (oMM_ADDR),
        .oMM_WR_DATA  (oMM_WR_DATA),
        .iMM_RD_DATA  (iMM_RD_DATA),
        .iMM_RD_DATA_V(iMM_RD_DATA_V),
        .oRD_CNT      (oRD_CNT),
        .oWR_CNT      (oWR_CNT),
        .oTO_CNT      (oTO_CNT)
    );

    // Single comparison point: every check funnels through here
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for ready, present one request, drop valid after accept.
    // Returns just after the accepting edge, i.e. inside the ISSUE cycle.
    task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
        int budget;
        budget = 50;
        while (!oREQ_READY && budget > 0) begin
            tick();
            budget--;
        end
        if (!oREQ_READY) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL reqReadyWait: got ready 0 after 50 cycles, required 1");
        end
        iREQ_VALID = 1'b1;
        iREQ_WR    = wr;
        iREQ_ADDR  = addr;
        iREQ_WDATA = wdata;
        tick();
        iREQ_VALID = 1'b0;
    endtask

    // Response monitor: a handshake must match the oldest queued expectation
    always @(negedge clk) begin
        if (oRSP_VALID && iRSP_READY) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedRsp: got data %h err %b, required no response",
                         oRSP_DATA, oRSP_ERR);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("rspData", oRSP_DATA, monExp.data);
                checkOutput("rspErr", 64'(oRSP_ERR), 64'(monExp.err));
            end
        end
    end

    // Hard stop in case the sequence wedges somewhere unbounded
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        iREQ_VALID    = 1'b0;
        iREQ_WR       = 1'b0;
        iREQ_ADDR     = '0;
        iREQ_WDATA    = '0;
        iRSP_READY    = 1'b1;
        iMM_RD_DATA   = '0;
        iMM_RD_DATA_V = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        checkOutput("rstReqReady", 64'(oREQ_READY), 64'd0);
        checkOutput("rstRspValid", 64'(oRSP_VALID), 64'd0);
        checkOutput("rstRspData", oRSP_DATA, 64'd0);
        checkOutput("rstRspErr", 64'(oRSP_ERR), 64'd0);
        checkOutput("rstWrEn", 64'(oMM_WR_EN), 64'd0);
        checkOutput("rstRdEn", 64'(oMM_RD_EN), 64'd0);
        checkOutput("rstMmAddr", 64'(oMM_ADDR), 64'd0);
        checkOutput("rstMmWdata", oMM_WR_DATA, 64'd0);
        checkOutput("rstRdCnt", 64'(oRD_CNT), 64'd0);
        checkOutput("rstWrCnt", 64'(oWR_CNT), 64'd0);
        checkOutput("rstToCnt", 64'(oTO_CNT), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", 64'(oREQ_READY), 64'd1);

        // Write: strobe at T+1, response at T+2 with zero data
        tick();
        expQ.push_back('{64'h0, 1'b0});
        applyStimulus(1'b1, 14'h0010, 64'h1234);
        @(negedge clk);
        checkOutput("wrIssueWrEn", 64'(oMM_WR_EN), 64'd1);
        checkOutput("wrIssueRdEn", 64'(oMM_RD_EN), 64'd0);
        checkOutput("wrIssueAddr", 64'(oMM_ADDR), 64'h0010);
        checkOutput("wrIssueData", oMM_WR_DATA, 64'h1234);
        @(negedge clk);
        checkOutput("wrRspValidT2", 64'(oRSP_VALID), 64'd1);
        checkOutput("wrEnOnePulse", 64'(oMM_WR_EN), 64'd0);
        checkOutput("mmAddrHold", 64'(oMM_ADDR), 64'h0010);

        // Read returning data three cycles after the read strobe
        expQ.push_back('{64'hCAFE, 1'b0});
        applyStimulus(1'b0, 14'h0400, 64'h0);
        @(negedge clk);
        checkOutput("rdIssueRdEn", 64'(oMM_RD_EN), 64'd1);
        checkOutput("rdIssueWrEn", 64'(oMM_WR_EN), 64'd0);
        checkOutput("rdIssueAddr", 64'(oMM_ADDR), 64'h0400);
        tick();
        tick();
        tick();
        iMM_RD_DATA_V = 1'b1;
        iMM_RD_DATA   = 64'hCAFE;
        tick();
        iMM_RD_DATA_V = 1'b0;
        iMM_RD_DATA   = '0;
        @(negedge clk);
        checkOutput("rdRspValid", 64'(oRSP_VALID), 64'd1);

        // Read timing out after 8 wait cycles, then a late data pulse
        expQ.push_back('{64'hDEADBEEF_00003FFF, 1'b1});
        applyStimulus(1'b0, 14'h3FFF, 64'h0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            @(negedge clk);
            checkOutput($sformatf("toWaitNoRsp%0d", k), 64'(oRSP_VALID), 64'd0);
        end
        tick();
        @(negedge clk);
        checkOutput("toRspValid", 64'(oRSP_VALID), 64'd1);
        tick();
        iMM_RD_DATA_V = 1'b1;
        iMM_RD_DATA   = 64'h9999;
        tick();
        iMM_RD_DATA_V = 1'b0;
        iMM_RD_DATA   = '0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("lateDataIgnored", 64'(oRSP_VALID), 64'd0);
        checkOutput("lateDataReady", 64'(oREQ_READY), 64'd1);
        checkOutput("cntRdA", 64'(oRD_CNT), STATS_ON ? 64'd2 : 64'd0);
        checkOutput("cntWrA", 64'(oWR_CNT), STATS_ON ? 64'd1 : 64'd0);
        checkOutput("cntToA", 64'(oTO_CNT), STATS_ON ? 64'd1 : 64'd0);

        // Response held for 10 cycles with a pending request and a stray pulse
        tick();
        iRSP_READY = 1'b0;
        expQ.push_back('{64'hA5A5, 1'b0});
        applyStimulus(1'b0, 14'h0200, 64'h0);
        tick();
        iMM_RD_DATA_V = 1'b1;
        iMM_RD_DATA   = 64'hA5A5;
        tick();
        iMM_RD_DATA_V = 1'b0;
        iREQ_VALID    = 1'b1;
        iREQ_WR       = 1'b1;
        iREQ_ADDR     = 14'h0222;
        iREQ_WDATA    = 64'h77;
        expQ.push_back('{64'h0, 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("holdValid", 64'(oRSP_VALID), 64'd1);
            checkOutput("holdData", oRSP_DATA, 64'hA5A5);
            checkOutput("holdErr", 64'(oRSP_ERR), 64'd0);
            checkOutput("holdReqReady", 64'(oREQ_READY), 64'd0);
            checkOutput("holdNoIssue", 64'(oMM_WR_EN), 64'd0);
            tick();
            iMM_RD_DATA_V = (i == 3);
            iMM_RD_DATA   = 64'hBAD;
        end
        iMM_RD_DATA_V = 1'b0;
        iRSP_READY    = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("backToBackReady", 64'(oREQ_READY), 64'd1);
        tick();
        iREQ_VALID = 1'b0;
        @(negedge clk);
        checkOutput("pendingWrEn", 64'(oMM_WR_EN), 64'd1);
        checkOutput("pendingAddr", 64'(oMM_ADDR), 64'h0222);
        checkOutput("pendingData", oMM_WR_DATA, 64'h77);

        // Reset while waiting on a read: no response, then normal traffic
        applyStimulus(1'b0, 14'h0155, 64'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("midRstReqReady", 64'(oREQ_READY), 64'd0);
        checkOutput("midRstRspValid", 64'(oRSP_VALID), 64'd0);
        checkOutput("midRstRdEn", 64'(oMM_RD_EN), 64'd0);
        checkOutput("midRstMmAddr", 64'(oMM_ADDR), 64'd0);
        checkOutput("midRstRspData", oRSP_DATA, 64'd0);
        checkOutput("midRstRdCnt", 64'(oRD_CNT), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterMidRst", 64'(oREQ_READY), 64'd1);
        tick();
        iMM_RD_DATA_V = 1'b1;
        iMM_RD_DATA   = 64'h4444;
        tick();
        iMM_RD_DATA_V = 1'b0;
        expQ.push_back('{64'h0, 1'b0});
        applyStimulus(1'b1, 14'h0ABC, 64'hFEED);
        @(negedge clk);
        checkOutput("postRstWrEn", 64'(oMM_WR_EN), 64'd1);

        // Data arriving in the timeout cycle wins over the timeout
        expQ.push_back('{64'hBEEF01, 1'b0});
        applyStimulus(1'b0, 14'h0077, 64'h0);
        for (int k = 1; k <= TIMEOUT; k++) tick();
        iMM_RD_DATA_V = 1'b1;
        iMM_RD_DATA   = 64'hBEEF01;
        tick();
        iMM_RD_DATA_V = 1'b0;
        @(negedge clk);
        checkOutput("raceRspValid", 64'(oRSP_VALID), 64'd1);
        checkOutput("raceRspErr", 64'(oRSP_ERR), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("cntRdB", 64'(oRD_CNT), STATS_ON ? 64'd1 : 64'd0);
        checkOutput("cntWrB", 64'(oWR_CNT), STATS_ON ? 64'd1 : 64'd0);
        checkOutput("cntToB", 64'(oTO_CNT), 64'd0);

        repeat (3) tick();
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
